// File: rtl/ycc422_to_rgb_if.sv
// Video bus between a 4:2:2 YCbCr source, the converter and the RGB sink.
// The source side drives the ycc_* group; the converter drives the rgb_* group.
interface ycc422_to_rgb_if;
    logic [15:0] ycc;
    logic        ycc_dv;
    logic        ycc_hs;
    logic        ycc_vs;
    logic [23:0] rgb;
    logic        rgb_dv;
    logic        rgb_hs;
    logic        rgb_vs;
    logic        line_end;

    modport master (
        output ycc, ycc_dv, ycc_hs, ycc_vs,
        input  rgb, rgb_dv, rgb_hs, rgb_vs, line_end
    );

    modport slave (
        input  ycc, ycc_dv, ycc_hs, ycc_vs,
        output rgb, rgb_dv, rgb_hs, rgb_vs, line_end
    );
endinterface

// File: rtl/ycc422_to_rgb.sv
// 4:2:2 YCbCr to 24-bit RGB, BT.709 full-range, Q12 coefficients.
// Five-cycle pipeline: p1 -> p2 -> (pairing) s3 -> (products) s4 -> (sum, clamp) rgb.
module ycc422_to_rgb #(
    parameter int         COLORDEPTH = 8,
    parameter logic [7:0] NEUTRAL_C  = 8'd128
) (
    input logic             clk,
    input logic             rst,
    ycc422_to_rgb_if.slave  vid
);

    localparam logic signed [13:0] K_R_CR = 14'sd6450;
    localparam logic signed [13:0] K_G_CB = 14'sd767;
    localparam logic signed [13:0] K_G_CR = 14'sd1917;
    localparam logic signed [13:0] K_B_CB = 14'sd7601;

    typedef struct packed {
        logic [COLORDEPTH-1:0] y;
        logic [COLORDEPTH-1:0] c;
        logic                  dv;
        logic                  ph;
    } tap_t;

    tap_t p1, p2, p3;
    logic ph_in;

    logic [COLORDEPTH-1:0] y_sel, cb_sel, cr_sel;

    logic [COLORDEPTH-1:0] s3_y;
    logic signed [8:0]     s3_cb, s3_cr;

    logic [COLORDEPTH-1:0] s4_y;
    logic signed [21:0]    s4_r_cr, s4_g_cb, s4_g_cr, s4_b_cb;

    logic signed [23:0] sum_r, sum_g, sum_b;
    logic [23:0]        rgb_q;

    logic [4:0] dv_sr, hs_sr, vs_sr;
    logic       le_q;

    function automatic logic [7:0] clamp8(input logic signed [23:0] v);
        logic signed [23:0] q;
        q = v >>> 12;
        if (q[23])
            return '0;
        else if (q > 24'sd255)
            return '1;
        else
            return q[7:0];
    endfunction

    // Phase restarts at even whenever the previous cycle carried no pixel.
    always_comb begin
        ph_in = 1'b0;
        if (p1.dv)
            ph_in = ~p1.ph;
    end

    // Delay line: advances every cycle, no stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else begin
            p1 <= '{vid.ycc[15:8], vid.ycc[7:0], vid.ycc_dv, ph_in};
            p2 <= p1;
            p3 <= p2;
        end
    end

    // Chroma pairing for the pixel at p2; p1 is its successor, p3 its predecessor.
    always_comb begin
        y_sel  = '0;
        cb_sel = NEUTRAL_C;
        cr_sel = NEUTRAL_C;
        if (p2.dv) begin
            y_sel = p2.y;
            if (!p2.ph) begin
                cb_sel = p2.c;
                if (p1.dv && p1.ph)
                    cr_sel = p1.c;
            end else begin
                cr_sel = p2.c;
                cb_sel = p3.c;
            end
        end
    end

    // Stage 3: remove chroma offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_y  <= '0;
            s3_cb <= '0;
            s3_cr <= '0;
        end else begin
            s3_y  <= y_sel;
            s3_cb <= $signed({1'b0, cb_sel}) - 9'sd128;
            s3_cr <= $signed({1'b0, cr_sel}) - 9'sd128;
        end
    end

    // Stage 4: coefficient products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s4_y    <= '0;
            s4_r_cr <= '0;
            s4_g_cb <= '0;
            s4_g_cr <= '0;
            s4_b_cb <= '0;
        end else begin
            s4_y    <= s3_y;
            s4_r_cr <= 22'(K_R_CR) * 22'(s3_cr);
            s4_g_cb <= 22'(K_G_CB) * 22'(s3_cb);
            s4_g_cr <= 22'(K_G_CR) * 22'(s3_cr);
            s4_b_cb <= 22'(K_B_CB) * 22'(s3_cb);
        end
    end

    // Rounded Q12 sums ahead of the clamp.
    always_comb begin
        sum_r = '0;
        sum_g = '0;
        sum_b = '0;
        sum_r = $signed({4'd0, s4_y, 12'd0}) + 24'(s4_r_cr) + 24'sd2048;
        sum_g = $signed({4'd0, s4_y, 12'd0}) - 24'(s4_g_cb) - 24'(s4_g_cr) + 24'sd2048;
        sum_b = $signed({4'd0, s4_y, 12'd0}) + 24'(s4_b_cb) + 24'sd2048;
    end

    // Stage 5: clamp and register the output pixel.
    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= '0;
        else
            rgb_q <= {clamp8(sum_r), clamp8(sum_g), clamp8(sum_b)};
    end

    // Timing signals follow the pixel through the same five stages; line end
    // marks the first cycle the delayed dv is low after being high.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
            le_q  <= 1'b0;
        end else begin
            dv_sr <= {dv_sr[3:0], vid.ycc_dv};
            hs_sr <= {hs_sr[3:0], vid.ycc_hs};
            vs_sr <= {vs_sr[3:0], vid.ycc_vs};
            le_q  <= dv_sr[4] & ~dv_sr[3];
        end
    end

    assign vid.rgb      = rgb_q;
    assign vid.rgb_dv   = dv_sr[4];
    assign vid.rgb_hs   = hs_sr[4];
    assign vid.rgb_vs   = vs_sr[4];
    assign vid.line_end = le_q;

endmodule

// File: tb/tb_ycc422_to_rgb.sv
// Bench for ycc422_to_rgb: constant vectors, hand-written corner sequences,
// and random traffic against a stream-level reference model.
module tb_ycc422_to_rgb;

    localparam int MAXC = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ycc422_to_rgb_if vid();

    ycc422_to_rgb #(.COLORDEPTH(8), .NEUTRAL_C(8'd128)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    // Input history and observed outputs, indexed by cycle.
    logic        h_rst [MAXC];
    logic        h_dv  [MAXC];
    logic        h_hs  [MAXC];
    logic        h_vs  [MAXC];
    logic [7:0]  h_y   [MAXC];
    logic [7:0]  h_c   [MAXC];
    logic        h_ph  [MAXC];
    logic [23:0] o_rgb [MAXC];
    logic        o_dv  [MAXC];
    logic        o_le  [MAXC];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  y0, c0, y1, c1;
        int          len;
        logic [23:0] e0, e1;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] clamp(input int v);
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    function automatic logic [23:0] conv(input int y, input int cb, input int cr);
        int r, g, b;
        r = (y * 4096 + 6450 * (cr - 128) + 2048) >>> 12;
        g = (y * 4096 - 767 * (cb - 128) - 1917 * (cr - 128) + 2048) >>> 12;
        b = (y * 4096 + 7601 * (cb - 128) + 2048) >>> 12;
        return {clamp(r), clamp(g), clamp(b)};
    endfunction

    function automatic bit rst_at(input int i);
        if (i < 0) return 1'b1;
        return h_rst[i];
    endfunction

    // A pixel from cycle t-5 survives only if no reset hit it on the way.
    function automatic bit flushed(input int t);
        for (int i = t - 5; i < t; i++)
            if (rst_at(i)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [23:0] exp_rgb(input int t);
        int k, cb, cr;
        k = t - 5;
        if (flushed(t) || !h_dv[k]) return 24'h0;
        if (!h_ph[k]) begin
            cb = int'(h_c[k]);
            cr = (h_dv[k + 1] && h_ph[k + 1]) ? int'(h_c[k + 1]) : 128;
        end else begin
            cr = int'(h_c[k]);
            cb = int'(h_c[k - 1]);
        end
        return conv(int'(h_y[k]), cb, cr);
    endfunction

    function automatic logic [2:0] exp_sync(input int t);
        if (flushed(t)) return 3'b000;
        return {h_dv[t - 5], h_hs[t - 5], h_vs[t - 5]};
    endfunction

    function automatic logic exp_le(input int t);
        logic [2:0] a, b;
        if (rst_at(t - 1)) return 1'b0;
        a = exp_sync(t - 1);
        b = exp_sync(t);
        return a[2] & ~b[2];
    endfunction

    // One clock: drive inputs, compare this cycle's outputs with the model.
    task automatic tick(input logic r, input logic d, input logic [7:0] y, input logic [7:0] c);
        logic h, v;
        h = 1'($urandom);
        v = 1'($urandom);
        rst        = r;
        vid.ycc_dv = d;
        vid.ycc_hs = h;
        vid.ycc_vs = v;
        vid.ycc    = {y, c};
        h_rst[cyc] = r;
        h_dv[cyc]  = d;
        h_hs[cyc]  = h;
        h_vs[cyc]  = v;
        h_y[cyc]   = y;
        h_c[cyc]   = c;
        h_ph[cyc]  = (cyc > 0 && h_dv[cyc - 1] && !h_rst[cyc - 1]) ? !h_ph[cyc - 1] : 1'b0;
        @(negedge clk);
        o_rgb[cyc] = vid.rgb;
        o_dv[cyc]  = vid.rgb_dv;
        o_le[cyc]  = vid.line_end;
        if (cyc >= 1) begin
            chk("model_rgb",  vid.rgb, exp_rgb(cyc));
            chk("model_sync", {21'd0, vid.rgb_dv, vid.rgb_hs, vid.rgb_vs}, {21'd0, exp_sync(cyc)});
            chk("model_le",   {23'd0, vid.line_end}, {23'd0, exp_le(cyc)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    initial begin
        int n, m;
        tbl[0] = '{8'd128, 8'd128, 8'd128, 8'd128, 2, 24'h808080, 24'h808080};
        tbl[1] = '{8'd100, 8'd128, 8'd100, 8'd160, 2, 24'h965564, 24'h965564};
        tbl[2] = '{8'd0,   8'd128, 8'd0,   8'd255, 2, 24'hC80000, 24'hC80000};
        tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd128, 2, 24'h001800, 24'h001800};
        tbl[4] = '{8'd255, 8'd255, 8'd255, 8'd128, 2, 24'hFFE7FF, 24'hFFE7FF};
        tbl[5] = '{8'd50,  8'd128, 8'd0,   8'd0,   1, 24'h323232, 24'h000000};

        vid.ycc_dv = 1'b0;
        vid.ycc_hs = 1'b0;
        vid.ycc_vs = 1'b0;
        vid.ycc    = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            tick(1'b1, 1'b0, 8'd0, 8'd0);
        chk("reset_rgb", o_rgb[cyc - 1], 24'h0);
        chk("reset_dv_le", {22'd0, o_dv[cyc - 1], o_le[cyc - 1]}, 24'h0);
        idle(2);

        // Constant vectors: one short line each.
        for (int i = 0; i < 6; i++) begin
            n = cyc;
            tick(1'b0, 1'b1, tbl[i].y0, tbl[i].c0);
            if (tbl[i].len == 2)
                tick(1'b0, 1'b1, tbl[i].y1, tbl[i].c1);
            idle(8);
            chk($sformatf("tbl%0d_rgb0", i), o_rgb[n + 5], tbl[i].e0);
            if (tbl[i].len == 2)
                chk($sformatf("tbl%0d_rgb1", i), o_rgb[n + 6], tbl[i].e1);
            chk($sformatf("tbl%0d_dv_first", i), {23'd0, o_dv[n + 5]}, 24'd1);
            chk($sformatf("tbl%0d_dv_before", i), {23'd0, o_dv[n + 4]}, 24'd0);
            chk($sformatf("tbl%0d_dv_after", i), {23'd0, o_dv[n + 5 + tbl[i].len]}, 24'd0);
            chk($sformatf("tbl%0d_le", i), {23'd0, o_le[n + 5 + tbl[i].len]}, 24'd1);
            chk($sformatf("tbl%0d_le_early", i), {23'd0, o_le[n + 4 + tbl[i].len]}, 24'd0);
            chk($sformatf("tbl%0d_le_once", i), {23'd0, o_le[n + 6 + tbl[i].len]}, 24'd0);
        end

        // Odd-length line, then a new line after a one-cycle gap.
        n = cyc;
        tick(1'b0, 1'b1, 8'd100, 8'd128);
        tick(1'b0, 1'b1, 8'd100, 8'd160);
        tick(1'b0, 1'b1, 8'd50,  8'd128);
        idle(1);
        m = cyc;
        tick(1'b0, 1'b1, 8'd100, 8'd128);
        tick(1'b0, 1'b1, 8'd100, 8'd160);
        idle(8);
        chk("odd_p0", o_rgb[n + 5], 24'h965564);
        chk("odd_p1", o_rgb[n + 6], 24'h965564);
        chk("odd_p2_neutral", o_rgb[n + 7], 24'h323232);
        chk("odd_le", {23'd0, o_le[n + 8]}, 24'd1);
        chk("gap_p0", o_rgb[m + 5], 24'h965564);
        chk("gap_p1", o_rgb[m + 6], 24'h965564);
        chk("gap_le", {23'd0, o_le[m + 7]}, 24'd1);

        // Reset asserted during pixel 2 of a 6-pixel line.
        n = cyc;
        for (int i = 0; i < 6; i++)
            tick(i == 2, 1'b1, 8'(80 + i), 8'd128);
        idle(8);
        chk("rstmid_rgb", o_rgb[n + 3], 24'h0);
        chk("rstmid_dv", {23'd0, o_dv[n + 3]}, 24'd0);
        for (int i = 3; i < 8; i++)
            chk("rstmid_no_le", {23'd0, o_le[n + i]}, 24'd0);
        chk("rstmid_tail", o_rgb[n + 8], 24'h535353);
        n = cyc;
        tick(1'b0, 1'b1, 8'd128, 8'd128);
        tick(1'b0, 1'b1, 8'd128, 8'd128);
        idle(8);
        chk("post_rst_p0", o_rgb[n + 5], 24'h808080);
        chk("post_rst_p1", o_rgb[n + 6], 24'h808080);
        chk("post_rst_le", {23'd0, o_le[n + 7]}, 24'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000 && cyc < MAXC - 16; i++)
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom));
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
